// File: rtl/rx_cmd_parser.sv
// Command parser between a UART receiver and a register file / ALU / UART transmitter.
// Decodes write, read, ALU and ALU-reuse frames and returns read or ALU results as response bytes.
module rx_cmd_parser #(
    parameter int ADDR_W = 4
) (
    input  logic              clck,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    input  logic [7:0]        rf_rd_data,
    input  logic              rf_rd_valid,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_fun,
    output logic              alu_en,
    input  logic [15:0]       alu_out,
    input  logic              alu_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              cmd_err,
    output logic              overrun
);

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU    = 8'hCC;
    localparam logic [7:0] CMD_ALU_RE = 8'hDD;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FUN,
        ALU_WAIT,
        TX_BYTE,
        TX_LO,
        TX_HI
    } state_t;

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] rf_addr_q,    rf_addr_d;
    logic [7:0]        rf_wr_data_q, rf_wr_data_d;
    logic              rf_wr_en_q,   rf_wr_en_d;
    logic              rf_rd_en_q,   rf_rd_en_d;
    logic [7:0]        alu_a_q,      alu_a_d;
    logic [7:0]        alu_b_q,      alu_b_d;
    logic [3:0]        alu_fun_q,    alu_fun_d;
    logic              alu_en_q,     alu_en_d;
    logic [7:0]        tx_data_q,    tx_data_d;
    logic [7:0]        res_hi_q,     res_hi_d;
    logic              cmd_err_q,    cmd_err_d;
    logic              overrun_q,    overrun_d;

    logic              in_tx;
    logic              drops_rx;

    // Response states present a byte; wait and response states cannot accept a new byte.
    assign in_tx    = (state_q == TX_BYTE) || (state_q == TX_LO) || (state_q == TX_HI);
    assign drops_rx = in_tx || (state_q == RD_WAIT) || (state_q == ALU_WAIT);

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        tx_data_d    = tx_data_q;
        res_hi_d     = res_hi_q;
        cmd_err_d    = 1'b0;
        overrun_d    = rx_valid && drops_rx;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WR:     state_d = WR_ADDR;
                        CMD_RD:     state_d = RD_ADDR;
                        CMD_ALU:    state_d = ALU_A;
                        CMD_ALU_RE: state_d = ALU_FUN;
                        default:    cmd_err_d = 1'b1;
                    endcase
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid) begin
                    tx_data_d = rf_rd_data;
                    state_d   = TX_BYTE;
                end
            end
            ALU_A: begin
                if (rx_valid) begin
                    alu_a_d = rx_data;
                    state_d = ALU_B;
                end
            end
            ALU_B: begin
                if (rx_valid) begin
                    alu_b_d = rx_data;
                    state_d = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_valid) begin
                    alu_fun_d = rx_data[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                // The high byte is parked until the low byte has been accepted.
                if (alu_valid) begin
                    tx_data_d = alu_out[7:0];
                    res_hi_d  = alu_out[15:8];
                    state_d   = TX_LO;
                end
            end
            TX_BYTE: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            TX_LO: begin
                if (tx_ready) begin
                    tx_data_d = res_hi_q;
                    state_d   = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            tx_data_q    <= '0;
            res_hi_q     <= '0;
            cmd_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            tx_data_q    <= tx_data_d;
            res_hi_q     <= res_hi_d;
            cmd_err_q    <= cmd_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_fun    = alu_fun_q;
    assign alu_en     = alu_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = in_tx;
    assign busy       = (state_q != IDLE);
    assign cmd_err    = cmd_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: frame-level reference model, register-file and ALU
// responders, random transmitter backpressure, and a monitor that checks every DUT strobe.
module tb_rx_cmd_parser;

    localparam int         ADDR_W = 4;
    localparam logic [7:0] AMASK  = 8'((1 << ADDR_W) - 1);

    logic              clck = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [7:0]        rf_rd_data;
    logic              rf_rd_valid;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_fun;
    logic              alu_en;
    logic [15:0]       alu_out;
    logic              alu_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              cmd_err;
    logic              overrun;

    always #5 clck = ~clck;

    rx_cmd_parser #(.ADDR_W(ADDR_W)) dut (
        .clck        (clck),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rf_addr     (rf_addr),
        .rf_wr_data  (rf_wr_data),
        .rf_wr_en    (rf_wr_en),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_data  (rf_rd_data),
        .rf_rd_valid (rf_rd_valid),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fun     (alu_fun),
        .alu_en      (alu_en),
        .alu_out     (alu_out),
        .alu_valid   (alu_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .cmd_err     (cmd_err),
        .overrun     (overrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: expected strobes and response bytes, in issue order.
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [19:0] alu_q[$];
    logic [7:0]  tx_q[$];
    int          err_tok = 0;
    int          ovr_tok = 0;

    // Responder scripts supplied by the stimulus.
    logic [7:0]  rd_data_q[$];
    int          rd_dly_q[$];
    int          alu_dly_q[$];

    // Reference model of the latched ALU operands.
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    bit          hold_ready = 1'b0;

    // Behaviour of the external ALU: odd codes add, even codes multiply.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        if (f[0]) return 16'(a) + 16'(b);
        return 16'(a) * 16'(b);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event seen with no expectation (t=%0t)", nm, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clck);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clck);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        idle($urandom_range(0, 2));
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        wr_q.push_back({addr & AMASK, data});
        send_byte(8'hAA); gap();
        send_byte(addr);  gap();
        send_byte(data);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] rdata, input int dly);
        rd_q.push_back(addr & AMASK);
        rd_data_q.push_back(rdata);
        rd_dly_q.push_back(dly);
        tx_q.push_back(rdata);
        send_byte(8'hBB); gap();
        send_byte(addr);
    endtask

    task automatic push_alu(input logic [7:0] fbyte, input int dly);
        logic [15:0] r;
        r = alu_ref(m_a, m_b, fbyte[3:0]);
        alu_q.push_back({m_a, m_b, fbyte[3:0]});
        tx_q.push_back(r[7:0]);
        tx_q.push_back(r[15:8]);
        alu_dly_q.push_back(dly);
    endtask

    task automatic do_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fbyte,
                          input int dly);
        m_a = a;
        m_b = b;
        push_alu(fbyte, dly);
        send_byte(8'hCC); gap();
        send_byte(a);     gap();
        send_byte(b);     gap();
        send_byte(fbyte);
    endtask

    task automatic do_reuse(input logic [7:0] fbyte, input int dly);
        push_alu(fbyte, dly);
        send_byte(8'hDD); gap();
        send_byte(fbyte);
    endtask

    task automatic bad_cmd(input logic [7:0] b);
        err_tok++;
        send_byte(b);
    endtask

    task automatic junk();
        ovr_tok++;
        send_byte(8'($urandom));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            idle(1);
            n++;
        end
        if (busy) flag("busy_timeout");
    endtask

    task automatic wait_txv();
        int n = 0;
        while (!tx_valid && n < 100) begin
            idle(1);
            n++;
        end
        if (!tx_valid) flag("tx_valid_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_addr"},    32'(rf_addr),    32'h0);
        check({tag, "_rf_wr_data"}, 32'(rf_wr_data), 32'h0);
        check({tag, "_alu_a"},      32'(alu_a),      32'h0);
        check({tag, "_alu_b"},      32'(alu_b),      32'h0);
        check({tag, "_alu_fun"},    32'(alu_fun),    32'h0);
        check({tag, "_tx_data"},    32'(tx_data),    32'h0);
        check({tag, "_strobes"},
              32'({rf_wr_en, rf_rd_en, alu_en, tx_valid, busy, cmd_err, overrun}), 32'h0);
    endtask

    // Transmitter: random backpressure unless the stimulus holds it off.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clck);
            #1;
            tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Register-file read responder.
    initial begin
        logic [7:0] d;
        int         dly;
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'h00;
        forever begin
            @(negedge clck);
            if (rf_rd_en && !rst) begin
                d   = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 8'h00;
                dly = (rd_dly_q.size() != 0) ? rd_dly_q.pop_front() : 0;
                idle(1 + dly);
                rf_rd_data  = d;
                rf_rd_valid = 1'b1;
                idle(1);
                rf_rd_valid = 1'b0;
                rf_rd_data  = 8'($urandom);
            end
        end
    end

    // ALU responder, computing from the operands the DUT presents.
    initial begin
        logic [15:0] r;
        int          dly;
        alu_valid = 1'b0;
        alu_out   = 16'h0000;
        forever begin
            @(negedge clck);
            if (alu_en && !rst) begin
                r   = alu_ref(alu_a, alu_b, alu_fun);
                dly = (alu_dly_q.size() != 0) ? alu_dly_q.pop_front() : 0;
                idle(1 + dly);
                alu_out   = r;
                alu_valid = 1'b1;
                idle(1);
                alu_valid = 1'b0;
                alu_out   = 16'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or transfers a byte.
    initial begin
        logic [15:0] we;
        logic [19:0] ae;
        logic [7:0]  te;
        logic [7:0]  prev_data;
        bit          prev_hold;
        bit          rsp_prev;
        prev_hold = 1'b0;
        rsp_prev  = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clck);
            if (rst) begin
                prev_hold = 1'b0;
                rsp_prev  = 1'b0;
            end else begin
                if (rf_wr_en) begin
                    if (wr_q.size() == 0) flag("rf_wr_en_unexpected");
                    else begin
                        we = wr_q.pop_front();
                        check("wr_addr", 32'(rf_addr),    32'(we[15:8]));
                        check("wr_data", 32'(rf_wr_data), 32'(we[7:0]));
                    end
                end
                if (rf_rd_en) begin
                    if (rd_q.size() == 0) flag("rf_rd_en_unexpected");
                    else check("rd_addr", 32'(rf_addr), 32'(rd_q.pop_front()));
                end
                if (alu_en) begin
                    if (alu_q.size() == 0) flag("alu_en_unexpected");
                    else begin
                        ae = alu_q.pop_front();
                        check("alu_a",   32'(alu_a),   32'(ae[19:12]));
                        check("alu_b",   32'(alu_b),   32'(ae[11:4]));
                        check("alu_fun", 32'(alu_fun), 32'(ae[3:0]));
                    end
                end
                if (cmd_err) begin
                    if (err_tok == 0) flag("cmd_err_unexpected");
                    else begin
                        err_tok--;
                        n_cmp++;
                    end
                end
                if (overrun) begin
                    if (ovr_tok == 0) flag("overrun_unexpected");
                    else begin
                        ovr_tok--;
                        n_cmp++;
                    end
                end
                if (rsp_prev) check("rsp_latency_tx_valid", 32'(tx_valid), 32'h1);
                if (prev_hold) begin
                    check("tx_hold_valid", 32'(tx_valid), 32'h1);
                    check("tx_hold_data",  32'(tx_data),  32'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) flag("tx_byte_unexpected");
                    else begin
                        te = tx_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(te));
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                rsp_prev  = rf_rd_valid || alu_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         kind;
        int         dly;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Single register write.
        do_write(8'h05, 8'h3C);
        check("wr_busy_after", 32'(busy), 32'h0);
        idle(3);

        // Read with upper address bits ignored, response held under backpressure.
        hold_ready = 1'b1;
        do_read(8'h12, 8'h7E, 2);
        wait_txv();
        for (int i = 0; i < 5; i++) begin
            check("rd_tx_held", 32'(tx_data), 32'h7E);
            idle(1);
        end
        hold_ready = 1'b0;
        wait_idle();
        check("rd_addr_kept", 32'(rf_addr), 32'h2);

        // ALU frame with overruns in ALU_WAIT and TX_LO, low byte held for 10 cycles.
        hold_ready = 1'b1;
        do_alu(8'h10, 8'h20, 8'h01, 5);
        idle(1);
        junk();
        wait_txv();
        for (int i = 0; i < 10; i++) begin
            check("tx_lo_held", 32'(tx_data), 32'h30);
            if (i == 4) junk();
            else idle(1);
        end
        hold_ready = 1'b0;
        wait_idle();

        // Reuse of latched operands.
        do_reuse(8'h02, 1);
        wait_idle();
        check("reuse_alu_a",   32'(alu_a),   32'h10);
        check("reuse_alu_b",   32'(alu_b),   32'h20);
        check("reuse_alu_fun", 32'(alu_fun), 32'h2);

        // Unknown command.
        bad_cmd(8'h55);
        check("bad_cmd_idle", 32'(busy), 32'h0);
        idle(2);

        // Reset in the middle of a write frame.
        send_byte(8'hAA);
        send_byte(8'h05);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_all_zero("mid_rst");
        m_a = 8'h00;
        m_b = 8'h00;
        do_write(8'h0A, 8'hC3);
        idle(3);

        // Randomized frame stream.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            dly  = $urandom_range(0, 6);
            case (kind)
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), 8'($urandom), dly);
                2: do_alu(8'($urandom), 8'($urandom), 8'($urandom), dly);
                3: do_reuse(8'($urandom), dly);
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    bad_cmd(b);
                end
            endcase
            if (kind == 1 || kind == 2 || kind == 3) begin
                if (dly >= 3 && $urandom_range(0, 1) == 1) begin
                    idle(1);
                    junk();
                end
                wait_idle();
            end
            gap();
        end

        idle(20);
        check("wr_q_left",   32'(wr_q.size()),  32'h0);
        check("rd_q_left",   32'(rd_q.size()),  32'h0);
        check("alu_q_left",  32'(alu_q.size()), 32'h0);
        check("tx_q_left",   32'(tx_q.size()),  32'h0);
        check("cmd_err_left", 32'(err_tok),     32'h0);
        check("overrun_left", 32'(ovr_tok),     32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width (1..8).
REQ-002 SHALL have port clck  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  in  8  received byte from the UART receiver.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe; rx_data valid in that cycle.
REQ-006 SHALL have port rf_addr  out  ADDR_W  register-file address.
REQ-007 SHALL have port rf_wr_data  out  8  register-file write data.
REQ-008 SHALL have port rf_wr_en  out  1  one-cycle write strobe.
REQ-009 SHALL have port rf_rd_en  out  1  one-cycle read strobe.
REQ-010 SHALL have port rf_rd_data  in  8  read data; sampled when rf_rd_valid=1.
REQ-011 SHALL have port rf_rd_valid  in  1  read-data strobe.
REQ-012 SHALL have ports alu_a, alu_b  out  8 each  ALU operands.
REQ-013 SHALL have port alu_fun  out  4  ALU function code.
REQ-014 SHALL have port alu_en  out  1  one-cycle ALU start strobe.
REQ-015 SHALL have port alu_out  in  16  ALU result; sampled when alu_valid=1.
REQ-016 SHALL have port alu_valid  in  1  result strobe.
REQ-017 SHALL have port tx_data  out  8  response byte to the transmitter.
REQ-018 SHALL have port tx_valid  out  1  response byte valid.
REQ-019 SHALL have port tx_ready  in  1  transmitter accepts tx_data.
REQ-020 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-021 SHALL have port cmd_err  out  1  one-cycle pulse: unknown command byte.
REQ-022 SHALL have port overrun  out  1  one-cycle pulse: byte dropped in a wait/TX state.

Function
REQ-023 SHALL use a registered FSM with states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE, TX_LO, TX_HI.
REQ-024 In IDLE, on rx_valid, SHALL decode rx_data: 0xAA->WR_ADDR; 0xBB->RD_ADDR; 0xCC->ALU_A; 0xDD->ALU_FUN; any other value->stay IDLE and pulse cmd_err next cycle.
REQ-025 Command frames: 0xAA,addr,data (write); 0xBB,addr (read); 0xCC,A,B,fun (ALU with operands); 0xDD,fun (ALU reusing the last latched alu_a/alu_b).
REQ-026 The address byte SHALL use bits [ADDR_W-1:0] only; upper bits ignored. The fun byte SHALL use bits [3:0] only.
REQ-027 In WR_DATA, on rx_valid: latch rf_wr_data, pulse rf_wr_en in the next cycle with rf_addr stable, return to IDLE.
REQ-028 In RD_ADDR, on rx_valid: latch rf_addr, pulse rf_rd_en next cycle, enter RD_WAIT.
REQ-029 In RD_WAIT: on rf_rd_valid, capture rf_rd_data into tx_data and enter TX_BYTE.
REQ-030 In ALU_FUN, on rx_valid: latch alu_fun, pulse alu_en next cycle, enter ALU_WAIT; on alu_valid, capture alu_out, enter TX_LO.
REQ-031 tx_valid SHALL be high in TX_BYTE/TX_LO/TX_HI; each byte is transferred on an edge where tx_valid=1 and tx_ready=1. tx_data SHALL stay stable until transfer.
REQ-032 TX_BYTE transfers -> IDLE. TX_LO sends alu_out[7:0] -> TX_HI. TX_HI sends alu_out[15:8] -> IDLE.
REQ-033 In RD_WAIT, ALU_WAIT and TX_* states, rx_valid SHALL be ignored (no state change) and overrun SHALL pulse once per dropped byte.
REQ-034 Response latency: an rf_rd_valid/alu_valid strobe SHALL produce tx_valid=1 on the following cycle.
REQ-035 alu_a/alu_b/alu_fun/rf_addr/rf_wr_data SHALL hold their last latched values between commands.
REQ-036 There is no timeout: a partially received frame waits indefinitely for its next byte.

Reset
REQ-037 While rst=1 at a clck edge: state=IDLE; every output register=0, including alu_a, alu_b, alu_fun, rf_addr, rf_wr_data, tx_data and all strobes.
REQ-038 rst asserted mid-frame or mid-transfer SHALL abort the frame with no pending strobe emitted afterwards.

Verification
REQ-039 Send AA,05,3C -> single rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; busy=0 afterwards.
REQ-040 Send BB,12 with ADDR_W=4, return rf_rd_data=0x7E -> rf_rd_en pulse with rf_addr=2; tx_data=0x7E; holds until tx_ready=1.
REQ-041 Send CC,10,20,01 and return alu_out=0x0030 -> alu_en pulse with a=0x10, b=0x20, fun=1; tx bytes 0x30 then 0x00. Then send DD,02 -> a/b unchanged, fun=2.
REQ-042 Send 0x55 in IDLE -> cmd_err pulse for one cycle; state stays IDLE.
REQ-043 Send a byte during ALU_WAIT -> overrun pulse; frame completes normally. Hold tx_ready=0 for 10 cycles in TX_LO -> tx_data held at the low byte.
REQ-044 Assert rst after AA,05 -> no rf_wr_en; all outputs return to 0 and the next AA frame executes correctly.
